tdc_word_reader: RTL and testbench

Readout-side companion to the 32-bit TDC hit latch. On a trigger it pulses the latch's capture enable, takes the held 32-bit word, and drains it to the readout hardware as a 5-byte frame over a valid/ready byte stream. The frame is one header byte followed by four data bytes, MSB first. It sits between the TDC latch bank and the readout FIFO/serial link, and it is the only block that drives the latch enable.

---
 rtl/tdc_word_reader_pkg.sv | 19 +
 rtl/tdc_word_reader.sv | 128 ++++++++++++
 tb/tb_tdc_word_reader.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/tdc_word_reader_pkg.sv
// Shared definitions for the TDC readout path: FSM states, frame geometry
// and the default header tag.
package tdc_word_reader_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LATCH = 2'd1,
        ST_CAPT  = 2'd2,
        ST_SEND  = 2'd3
    } rd_state_e;

    localparam int unsigned FRAME_BYTES     = 5;
    localparam int unsigned TDC_WORD_W      = 32;
    localparam logic [3:0]  HDR_TAG_DEFAULT = 4'hA;

    localparam int unsigned IDX_W    = 3;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_BYTES - 1);

endpackage

// File: rtl/tdc_word_reader.sv
// Trigger-driven reader for the 32-bit TDC hit latch: pulses the latch enable,
// captures the held word and streams it as a header + 4 data byte frame.
module tdc_word_reader
    import tdc_word_reader_pkg::*;
#(
    parameter logic [3:0]  HDR_TAG = HDR_TAG_DEFAULT,
    parameter int unsigned OVR_W   = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  trig,
    output logic                  latch_en,
    input  logic [TDC_WORD_W-1:0] latch_q,
    output logic [7:0]            out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_last,
    output logic                  busy,
    output logic [3:0]            seq,
    output logic [OVR_W-1:0]      ovr_cnt
);

    localparam logic [OVR_W-1:0] OVR_MAX = {OVR_W{1'b1}};

    rd_state_e             state_q, state_d;
    logic [TDC_WORD_W-1:0] word_q,  word_d;
    logic [IDX_W-1:0]      idx_q,   idx_d;
    logic [3:0]            seq_q,   seq_d;
    logic [OVR_W-1:0]      ovr_q,   ovr_d;

    logic handshake;
    logic last_hs;
    logic drop;

    // NOTE: every signal assigned in this block gets a default first, so no
    // path through the case statement can leave a latch behind.
    always_comb begin
        state_d = state_q;
        word_d  = word_q;
        idx_d   = idx_q;
        seq_d   = seq_q;
        ovr_d   = ovr_q;

        handshake = (state_q == ST_SEND) && out_ready;
        last_hs   = handshake && (idx_q == LAST_IDX);
        drop      = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (trig) begin
                    state_d = ST_LATCH;
                    seq_d   = seq_q + 4'd1;
                end
            end
            ST_LATCH: begin
                drop    = trig;
                state_d = ST_CAPT;
            end
            ST_CAPT: begin
                drop    = trig;
                word_d  = latch_q;
                idx_d   = '0;
                state_d = ST_SEND;
            end
            ST_SEND: begin
                // A trigger coinciding with the final handshake starts the next frame.
                drop = trig && !last_hs;
                if (last_hs) begin
                    idx_d = '0;
                    if (trig) begin
                        state_d = ST_LATCH;
                        seq_d   = seq_q + 4'd1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else if (handshake) begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (drop && (ovr_q != OVR_MAX)) begin
            ovr_d = ovr_q + OVR_W'(1);
        end
    end

    // NOTE: sequential state is updated with non-blocking assignments only, so
    // every flop samples the pre-edge value of every other flop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            word_q  <= '0;
            idx_q   <= '0;
            seq_q   <= '0;
            ovr_q   <= '0;
        end else begin
            state_q <= state_d;
            word_q  <= word_d;
            idx_q   <= idx_d;
            seq_q   <= seq_d;
            ovr_q   <= ovr_d;
        end
    end

    // Outputs decode registered state only; out_data reads 0 outside SEND.
    always_comb begin
        out_data = 8'h00;
        if (state_q == ST_SEND) begin
            unique case (idx_q)
                3'd0:    out_data = {HDR_TAG, seq_q};
                3'd1:    out_data = word_q[31:24];
                3'd2:    out_data = word_q[23:16];
                3'd3:    out_data = word_q[15:8];
                3'd4:    out_data = word_q[7:0];
                default: out_data = 8'h00;
            endcase
        end
    end

    assign latch_en  = (state_q == ST_LATCH);
    assign out_valid = (state_q == ST_SEND);
    assign out_last  = (state_q == ST_SEND) && (idx_q == LAST_IDX);
    assign busy      = (state_q != ST_IDLE);
    assign seq       = seq_q;
    assign ovr_cnt   = ovr_q;

endmodule

// File: tb/tb_tdc_word_reader.sv
// Directed bench for tdc_word_reader: a per-cycle vector table for the basic
// frame, plus hand-written sequences for backpressure, overrun and reset cases.
module tb_tdc_word_reader;

    logic        clk = 1'b0;
    logic        rst;
    logic        trig;
    logic        latch_en;
    logic [31:0] latch_q;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready;
    logic        out_last;
    logic        busy;
    logic [3:0]  seq;
    logic [7:0]  ovr_cnt;

    int n_checks = 0;
    int n_errors = 0;

    tdc_word_reader #(.HDR_TAG(4'hA), .OVR_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .trig      (trig),
        .latch_en  (latch_en),
        .latch_q   (latch_q),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last),
        .busy      (busy),
        .seq       (seq),
        .ovr_cnt   (ovr_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        trig;
        logic        ready;
        logic [31:0] lq;
        logic        exp_latch_en;
        logic        exp_valid;
        logic [7:0]  exp_data;
        logic        exp_last;
        logic        exp_busy;
    } vec_t;

    vec_t vecs [9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Advance to just after the next rising edge; inputs change only here.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        trig      = 1'b0;
        out_ready = 1'b1;
        step();
        step();
        check("rst_latch_en", 32'(latch_en), 32'd0);
        check("rst_valid",    32'(out_valid), 32'd0);
        check("rst_data",     32'(out_data), 32'd0);
        check("rst_busy",     32'(busy), 32'd0);
        check("rst_seq",      32'(seq), 32'd0);
        check("rst_ovr",      32'(ovr_cnt), 32'd0);
        rst = 1'b0;
    endtask

    function automatic logic [7:0] exp_byte(input logic [3:0] s, input logic [31:0] w, input int n);
        logic [31:0] sh;
        if (n == 0) return {4'hA, s};
        sh = w >> (8 * (4 - n));
        return sh[7:0];
    endfunction

    // Starts from IDLE, pulses trig once and collects the whole frame.
    task automatic run_frame(input logic [3:0] exp_seq, input logic [31:0] w, input bit toggle);
        int   n;
        int   cyc;
        bit   stalled;
        logic [7:0] prev;
        latch_q = w;
        trig    = 1'b1;
        step();
        trig = 1'b0;
        check("frm_latch_en", 32'(latch_en), 32'd1);
        out_ready = toggle ? 1'b0 : 1'b1;
        n = 0;
        cyc = 0;
        stalled = 1'b0;
        while (n < 5 && cyc < 100) begin
            stalled = 1'b0;
            if (out_valid) begin
                if (out_ready) begin
                    check($sformatf("frm_byte%0d", n), 32'(out_data), 32'(exp_byte(exp_seq, w, n)));
                    check($sformatf("frm_last%0d", n), 32'(out_last), 32'(n == 4));
                    n++;
                end else begin
                    stalled = 1'b1;
                    prev    = out_data;
                end
            end
            step();
            if (stalled) check("frm_hold", 32'(out_data), 32'(prev));
            if (toggle) out_ready = ~out_ready;
            cyc++;
        end
        check("frm_complete", n, 5);
        check("frm_idle_after", 32'(busy), 32'd0);
        out_ready = 1'b1;
    endtask

    initial begin
        int lasts;
        int cyc;

        latch_q = 32'hDEADBEEF;
        do_reset();

        // Basic frame with capture isolation: latch_q changes after CAPT.
        vecs[0] = '{1'b1, 1'b1, 32'hDEADBEEF, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0};
        vecs[1] = '{1'b0, 1'b1, 32'hDEADBEEF, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1};
        vecs[2] = '{1'b0, 1'b1, 32'hDEADBEEF, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1};
        vecs[3] = '{1'b0, 1'b1, 32'h12345678, 1'b0, 1'b1, 8'hA1, 1'b0, 1'b1};
        vecs[4] = '{1'b0, 1'b1, 32'h12345678, 1'b0, 1'b1, 8'hDE, 1'b0, 1'b1};
        vecs[5] = '{1'b0, 1'b1, 32'h12345678, 1'b0, 1'b1, 8'hAD, 1'b0, 1'b1};
        vecs[6] = '{1'b0, 1'b1, 32'h12345678, 1'b0, 1'b1, 8'hBE, 1'b0, 1'b1};
        vecs[7] = '{1'b0, 1'b1, 32'h12345678, 1'b0, 1'b1, 8'hEF, 1'b1, 1'b1};
        vecs[8] = '{1'b0, 1'b1, 32'h12345678, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0};
        for (int i = 0; i < 9; i++) begin
            check($sformatf("vec%0d_latch_en", i), 32'(latch_en), 32'(vecs[i].exp_latch_en));
            check($sformatf("vec%0d_valid", i),    32'(out_valid), 32'(vecs[i].exp_valid));
            check($sformatf("vec%0d_data", i),     32'(out_data), 32'(vecs[i].exp_data));
            check($sformatf("vec%0d_last", i),     32'(out_last), 32'(vecs[i].exp_last));
            check($sformatf("vec%0d_busy", i),     32'(busy), 32'(vecs[i].exp_busy));
            trig      = vecs[i].trig;
            out_ready = vecs[i].ready;
            latch_q   = vecs[i].lq;
            step();
        end
        trig = 1'b0;

        // Backpressure: ready toggles every cycle, frame carries seq 2.
        run_frame(4'd2, 32'hDEADBEEF, 1'b1);

        // Trigger on the final-byte handshake chains straight into LATCH.
        do_reset();
        latch_q = 32'hDEADBEEF;
        trig = 1'b1;
        step();
        trig = 1'b0;
        cyc = 0;
        while (!out_last && cyc < 50) begin
            step();
            cyc++;
        end
        check("chain_reach_last", 32'(out_last), 32'd1);
        trig = 1'b1;
        step();
        trig = 1'b0;
        check("chain_latch_en", 32'(latch_en), 32'd1);
        check("chain_busy", 32'(busy), 32'd1);
        step();
        check("chain_no_repeat_latch", 32'(latch_en), 32'd0);
        step();
        check("chain_hdr", 32'(out_data), 32'hA2);
        check("chain_ovr", 32'(ovr_cnt), 32'd0);
        cyc = 0;
        while (busy && cyc < 50) begin
            step();
            cyc++;
        end
        check("chain_drained", 32'(busy), 32'd0);

        // Overrun: drops in LATCH, CAPT and twice in SEND.
        do_reset();
        out_ready = 1'b0;
        trig = 1'b1;
        step();
        step();
        step();
        step();
        step();
        trig = 1'b0;
        check("ovr_four", 32'(ovr_cnt), 32'd4);
        out_ready = 1'b1;
        lasts = 0;
        for (int i = 0; i < 40; i++) begin
            if (out_valid && out_ready && out_last) lasts++;
            step();
        end
        check("ovr_one_frame", lasts, 1);

        // Held trig saturates the counter instead of wrapping.
        trig = 1'b1;
        for (int i = 0; i < 350; i++) step();
        trig = 1'b0;
        check("ovr_saturated", 32'(ovr_cnt), 32'd255);
        cyc = 0;
        while (busy && cyc < 50) begin
            step();
            cyc++;
        end
        check("sat_drained", 32'(busy), 32'd0);

        // Sequence wrap: 16th frame header is A0.
        do_reset();
        for (int i = 1; i <= 16; i++) begin
            run_frame(4'(i), 32'h0BADF00D + 32'(i), 1'b0);
        end
        check("wrap_seq", 32'(seq), 32'd0);

        // Reset during byte 2 of the next frame.
        trig = 1'b1;
        step();
        trig = 1'b0;
        step();
        step();
        step();
        step();
        check("mid_byte2", 32'(out_data), 32'hAD);
        #2;
        rst = 1'b1;
        #1;
        check("mid_valid", 32'(out_valid), 32'd0);
        check("mid_data",  32'(out_data), 32'd0);
        check("mid_last",  32'(out_last), 32'd0);
        check("mid_busy",  32'(busy), 32'd0);
        check("mid_seq",   32'(seq), 32'd0);
        step();
        check("mid_last_held", 32'(out_last), 32'd0);
        rst = 1'b0;
        step();
        check("post_rst_idle", 32'(busy), 32'd0);
        run_frame(4'd1, 32'hCAFEF00D, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
